// File: rtl/fifo_wptr_full_pkg.sv
// Shared pointer helpers for the asynchronous FIFO read and write sides:
// pointer-width derivation and binary/Gray conversions.
package fifo_wptr_full_pkg;

   localparam int unsigned CONV_W = 32;

   // Pointer width for a given depth: address bits plus one wrap bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [CONV_W-1:0] bin_to_gray(input logic [CONV_W-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [CONV_W-1:0] gray_to_bin(input logic [CONV_W-1:0] g);
      logic [CONV_W-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < CONV_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin.sv
// Parameterized combinational Gray-to-binary converter, shared by the
// write-side full controller and the read-side empty controller.
module fifo_wptr_full_gray2bin
   import fifo_wptr_full_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] GRAY,
   output logic [WIDTH-1:0] BIN
);

   always_comb begin
      BIN = WIDTH'(gray_to_bin(CONV_W'(GRAY)));
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag controller of the asynchronous FIFO.
// Optional overflow reporting (W_OVF, W_OVF_CNT) is enabled by FIFO_WR_OVF_EN.
module fifo_wptr_full
   import fifo_wptr_full_pkg::*;
#(
   parameter int MEM_DEPTH = 8,
   parameter int PTR_SIZE  = int'(ptr_width(MEM_DEPTH)),
   parameter int ADDR_SIZE = PTR_SIZE - 1,
   parameter int AF_LEVEL  = MEM_DEPTH - 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 W_INC,
   input  logic [PTR_SIZE-1:0]  RQ2_PTR,
   output logic                 W_EN,
   output logic [ADDR_SIZE-1:0] W_ADDR,
   output logic [PTR_SIZE-1:0]  W_PTR,
   output logic                 W_FULL,
   output logic                 W_ALMOST_FULL,
`ifdef FIFO_WR_OVF_EN
   output logic [PTR_SIZE-1:0]  W_LEVEL,
   output logic                 W_OVF,
   output logic [7:0]           W_OVF_CNT
`else
   output logic [PTR_SIZE-1:0]  W_LEVEL
`endif
);

   logic [PTR_SIZE-1:0] bin_q;
   logic [PTR_SIZE-1:0] bin_next;
   logic [PTR_SIZE-1:0] gray_next;
   logic [PTR_SIZE-1:0] rbin;
   logic [PTR_SIZE-1:0] level_next;
   logic [PTR_SIZE-1:0] full_match;
   logic                accept;
   logic                full_next;
   logic                af_next;

   fifo_wptr_full_gray2bin #(
      .WIDTH (PTR_SIZE)
   ) u_rq2_g2b (
      .GRAY (RQ2_PTR),
      .BIN  (rbin)
   );

   // Full when the next write pointer equals the read pointer with its
   // two MSBs inverted, i.e. exactly one lap ahead in Gray space.
   always_comb begin
      accept     = W_INC & ~W_FULL & ~RST;
      bin_next   = bin_q + PTR_SIZE'(accept);
      gray_next  = PTR_SIZE'(bin_to_gray(CONV_W'(bin_next)));
      full_match = {~RQ2_PTR[PTR_SIZE-1 -: 2], RQ2_PTR[PTR_SIZE-3:0]};
      full_next  = (gray_next == full_match);
      level_next = bin_next - rbin;
      af_next    = (level_next >= PTR_SIZE'(AF_LEVEL));
   end

   always_comb begin
      W_EN   = accept;
      W_ADDR = bin_q[ADDR_SIZE-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bin_q         <= '0;
         W_PTR         <= '0;
         W_FULL        <= 1'b0;
         W_ALMOST_FULL <= 1'b0;
         W_LEVEL       <= '0;
      end else begin
         bin_q         <= bin_next;
         W_PTR         <= gray_next;
         W_FULL        <= full_next;
         W_ALMOST_FULL <= af_next;
         W_LEVEL       <= level_next;
      end
   end

`ifdef FIFO_WR_OVF_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         W_OVF     <= 1'b0;
         W_OVF_CNT <= '0;
      end else if (W_INC & W_FULL) begin
         W_OVF <= 1'b1;
         if (W_OVF_CNT != '1) begin
            W_OVF_CNT <= W_OVF_CNT + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized self-checking bench for fifo_wptr_full against an occupancy-count model.
module tb_fifo_wptr_full;

   localparam int DEPTH = 8;
   localparam int PW    = 4;
   localparam int AW    = 3;
   localparam int AF    = DEPTH - 2;

   logic          CLK;
   logic          RST;
   logic          W_INC;
   logic [PW-1:0] RQ2_PTR;
   logic          W_EN;
   logic [AW-1:0] W_ADDR;
   logic [PW-1:0] W_PTR;
   logic          W_FULL;
   logic          W_ALMOST_FULL;
   logic [PW-1:0] W_LEVEL;
`ifdef FIFO_WR_OVF_EN
   logic          W_OVF;
   logic [7:0]    W_OVF_CNT;
`endif

   fifo_wptr_full #(
      .MEM_DEPTH (DEPTH)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .W_INC         (W_INC),
      .RQ2_PTR       (RQ2_PTR),
      .W_EN          (W_EN),
      .W_ADDR        (W_ADDR),
      .W_PTR         (W_PTR),
      .W_FULL        (W_FULL),
      .W_ALMOST_FULL (W_ALMOST_FULL),
`ifdef FIFO_WR_OVF_EN
      .W_LEVEL       (W_LEVEL),
      .W_OVF         (W_OVF),
      .W_OVF_CNT     (W_OVF_CNT)
`else
      .W_LEVEL       (W_LEVEL)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   // Model: total words accepted and total words the read side has consumed.
   int wcount = 0;
   int rcount = 0;
   int e_lvl  = 0;
   bit e_full = 1'b0;
   bit e_af   = 1'b0;
   int e_ptr  = 0;
   bit e_ovf  = 1'b0;
   int e_cnt  = 0;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_r(input int rc);
      rcount  = rc;
      RQ2_PTR = PW'(gray(rc % (2 * DEPTH)));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   always @(posedge CLK) begin
      if (RST) begin
         wcount = 0;
         e_lvl  = 0;
         e_full = 1'b0;
         e_af   = 1'b0;
         e_ptr  = 0;
         e_ovf  = 1'b0;
         e_cnt  = 0;
      end else begin
         if (W_INC && e_full) begin
            e_ovf = 1'b1;
            if (e_cnt < 255) e_cnt++;
         end
         if (W_INC && !e_full) wcount++;
         e_lvl  = wcount - rcount;
         e_full = (e_lvl == DEPTH);
         e_af   = (e_lvl >= AF);
         e_ptr  = gray(wcount % (2 * DEPTH));
      end
   end

   always @(negedge CLK) begin
      if (started) begin
         chk("w_en",   int'(W_EN),   int'(W_INC && !e_full && !RST));
         chk("w_addr", int'(W_ADDR), wcount % DEPTH);
         chk("w_ptr",  int'(W_PTR),  e_ptr);
         chk("w_full", int'(W_FULL), int'(e_full));
         chk("w_af",   int'(W_ALMOST_FULL), int'(e_af));
         chk("w_lvl",  int'(W_LEVEL), e_lvl);
`ifdef FIFO_WR_OVF_EN
         chk("w_ovf",     int'(W_OVF),     int'(e_ovf));
         chk("w_ovf_cnt", int'(W_OVF_CNT), e_cnt);
`endif
      end
   end

   int seq [9];

   initial begin
      seq = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
      RST   = 1'b1;
      W_INC = 1'b1;
      set_r(0);
      #1 chk("rst_wen", int'(W_EN), 0);
      tick();
      tick();
      started = 1'b1;
      chk("rst_wen2", int'(W_EN), 0);
      chk("rst_ptr",  int'(W_PTR), 0);
      chk("rst_full", int'(W_FULL), 0);
      chk("rst_af",   int'(W_ALMOST_FULL), 0);
      chk("rst_lvl",  int'(W_LEVEL), 0);
      chk("rst_addr", int'(W_ADDR), 0);
      RST   = 1'b0;
      W_INC = 1'b0;
      tick();

      // Fill from empty with the read pointer parked at 0.
      for (int k = 0; k < DEPTH; k++) begin
         W_INC = 1'b1;
         #1 chk("fill_addr", int'(W_ADDR), k);
         chk("fill_wen", int'(W_EN), 1);
         tick();
         chk("fill_ptr",  int'(W_PTR), seq[k+1]);
         chk("fill_af",   int'(W_ALMOST_FULL), int'(k + 1 >= 6));
         chk("fill_full", int'(W_FULL), int'(k + 1 == 8));
      end
      chk("fill_lvl", int'(W_LEVEL), 8);

      for (int k = 0; k < 3; k++) begin
         W_INC = 1'b1;
         #1 chk("drop_wen", int'(W_EN), 0);
         tick();
         chk("drop_ptr", int'(W_PTR), 12);
      end
      W_INC = 1'b0;
`ifdef FIFO_WR_OVF_EN
      chk("ovf_flag", int'(W_OVF), 1);
      chk("ovf_cnt",  int'(W_OVF_CNT), 3);
`endif

      set_r(1);
      tick();
      chk("unfull_full", int'(W_FULL), 0);
      chk("unfull_lvl",  int'(W_LEVEL), 7);
      chk("unfull_af",   int'(W_ALMOST_FULL), 1);

      set_r(8);
      tick();
      chk("drain_lvl", int'(W_LEVEL), 0);
      W_INC = 1'b1;
      tick();
      tick();
      chk("trail_start", int'(W_LEVEL), 2);
      for (int k = 0; k < 40; k++) begin
         set_r(wcount - 1);
         #1 chk("trail_addr", int'(W_ADDR), wcount % DEPTH);
         tick();
         chk("trail_lvl",  int'(W_LEVEL), 2);
         chk("trail_full", int'(W_FULL), 0);
      end

      W_INC = 1'b0;
      set_r(wcount - 5);
      tick();
      chk("l5_lvl", int'(W_LEVEL), 5);
      W_INC = 1'b1;
      set_r(rcount + 1);
      tick();
      chk("l5_both_lvl",  int'(W_LEVEL), 5);
      chk("l5_both_full", int'(W_FULL), 0);
      chk("l5_both_af",   int'(W_ALMOST_FULL), 0);
      W_INC = 1'b0;

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            RST   = 1'b1;
            W_INC = 1'($urandom_range(0, 1));
            set_r(0);
         end else begin
            RST   = 1'b0;
            W_INC = ($urandom_range(0, 3) != 0);
            if (rcount < wcount && $urandom_range(0, 1) == 1) begin
               set_r(rcount + int'($urandom_range(1, wcount - rcount)));
            end
         end
         tick();
      end
      RST   = 1'b0;
      W_INC = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
